// File: rtl/des_key_sched.sv
// DES key schedule: streams the 16 round subkeys K1..K16 (or K16..K1) over a valid/ready port.
// Define DES_KS_RESTART_EN to let start abort and reload a schedule that is in progress.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        done
);

  typedef enum logic {IDLE, ROUND} state_t;

  // Tables hold FIPS 46-3 bit numbers (1-based, bit 1 = MSB of each bus)
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic        dec_mode;
  logic [27:0] c_reg, d_reg;
  logic [55:0] pc1_out;
  logic [55:0] cd;
  logic        load;
  logic        last;
  logic        one_step;

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  always_comb begin
    pc1_out = '0;
    for (int j = 0; j < 56; j++) pc1_out[55-j] = key[64-PC1[j]];
  end

  assign cd = {c_reg, d_reg};

  // The subkey depends only on the C,D registers, never directly on the key input
  always_comb begin
    subkey = '0;
    for (int j = 0; j < 48; j++) subkey[47-j] = cd[56-PC2[j]];
  end

`ifdef DES_KS_RESTART_EN
  assign load = start;
`else
  assign load = start && (state == IDLE);
`endif

  assign last = dec_mode ? (round_idx == 4'd0) : (round_idx == 4'd15);

  // Rounds whose next step uses a single-bit rotation (shift table entries 1, 2, 9, 16)
  assign one_step = dec_mode
    ? (round_idx == 4'd0 || round_idx == 4'd1 || round_idx == 4'd8 || round_idx == 4'd15)
    : (round_idx == 4'd0 || round_idx == 4'd7 || round_idx == 4'd14);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
      round_idx    <= 4'd0;
      dec_mode     <= 1'b0;
      c_reg        <= '0;
      d_reg        <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state        <= ROUND;
        busy         <= 1'b1;
        subkey_valid <= 1'b1;
        dec_mode     <= decrypt;
        // Decrypt starts from C16,D16, which equal C0,D0 because the shifts total 28
        c_reg        <= decrypt ? pc1_out[55:28] : rotl(pc1_out[55:28], 1'b0);
        d_reg        <= decrypt ? pc1_out[27:0]  : rotl(pc1_out[27:0], 1'b0);
        round_idx    <= decrypt ? 4'd15 : 4'd0;
      end else if (state == ROUND && subkey_ready) begin
        c_reg <= dec_mode ? rotr(c_reg, !one_step) : rotl(c_reg, !one_step);
        d_reg <= dec_mode ? rotr(d_reg, !one_step) : rotl(d_reg, !one_step);
        if (last) begin
          state        <= IDLE;
          busy         <= 1'b0;
          subkey_valid <= 1'b0;
          done         <= 1'b1;
        end else begin
          round_idx <= dec_mode ? round_idx - 4'd1 : round_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a table-driven DES key schedule model.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        done;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [47:0] exp_keys [16];
  logic [47:0] obs_keys [16];

  int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .busy         (busy),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Kn computed directly: C,D of round n are C0,D0 rotated left by the cumulative shift
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
    int tot = 0;
    int p;
    logic c0 [28];
    logic d0 [28];
    logic [47:0] r = '0;
    for (int i = 0; i < n; i++) tot += SHIFTS[i];
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64-PC1[i]];
      d0[i] = k[64-PC1[28+i]];
    end
    for (int j = 0; j < 48; j++) begin
      p = PC2[j];
      r[47-j] = (p <= 28) ? c0[(p - 1 + tot) % 28] : d0[(p - 29 + tot) % 28];
    end
    return r;
  endfunction

  task automatic build_ref(input logic [63:0] k);
    for (int n = 1; n <= 16; n++) exp_keys[n-1] = model_subkey(k, n);
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},   48'(busy),         48'd0);
    checkOutput({tag, "_valid"},  48'(subkey_valid), 48'd0);
    checkOutput({tag, "_done"},   48'(done),         48'd0);
    checkOutput({tag, "_idx"},    48'(round_idx),    48'd0);
    checkOutput({tag, "_subkey"}, subkey,            48'd0);
  endtask

  // Issues start at the current negedge, then streams with subkey_ready high pct% of cycles.
  // stop_at >= 0 returns (ready low) while the stop_at-th transfer's subkey is presented.
  task automatic applyStimulus(input logic [63:0] k, input logic dec, input int pct, input int stop_at);
    int t = 0;
    int cyc = 0;
    int idx;
    build_ref(k);
    key = k;
    decrypt = dec;
    start = 1'b1;
    subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (t < 16 && cyc < 400) begin
      idx = dec ? 15 - t : t;
      checkOutput("valid",     48'(subkey_valid), 48'd1);
      checkOutput("busy",      48'(busy),         48'd1);
      checkOutput("done_early", 48'(done),        48'd0);
      checkOutput("round_idx", 48'(round_idx),    48'(idx));
      checkOutput("subkey",    subkey,            exp_keys[idx]);
      obs_keys[idx] = subkey;
      if (t == stop_at) begin
        subkey_ready = 1'b0;
        return;
      end
      subkey_ready = ($urandom_range(99) < pct);
      if (subkey_ready) t++;
      @(negedge clk);
      cyc++;
    end
    subkey_ready = 1'b0;
    checkOutput("transfers",  48'(t),            48'd16);
    checkOutput("done_pulse", 48'(done),         48'd1);
    checkOutput("done_busy",  48'(busy),         48'd0);
    checkOutput("done_valid", 48'(subkey_valid), 48'd0);
  endtask

  initial begin
    logic [63:0] new_key;
    logic [47:0] saved_next;
    rst_n = 1'b0;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 100, -1);
    checkOutput("enc_k1",  obs_keys[0],  48'h1B02EFFC7072);
    checkOutput("enc_k2",  obs_keys[1],  48'h79AED9DBC9E5);
    checkOutput("enc_k16", obs_keys[15], 48'hCB3D8B0E17F5);
    @(negedge clk);
    checkOutput("done_width", 48'(done), 48'd0);
    checkOutput("idle_busy",  48'(busy), 48'd0);

    applyStimulus(64'h133457799BBCDFF1, 1'b1, 100, -1);
    checkOutput("dec_first", obs_keys[15], 48'hCB3D8B0E17F5);
    checkOutput("dec_last",  obs_keys[0],  48'h1B02EFFC7072);
    @(negedge clk);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 50, -1);
    for (int r = 0; r < 4; r++)
      applyStimulus({$urandom, $urandom}, 1'($urandom_range(1)), 60, -1);
    applyStimulus(64'h0, 1'b0, 100, -1);
    @(negedge clk);
    checkOutput("gap_done_clear", 48'(done), 48'd0);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 100, 7);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("midreset");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midreset_no_done", 48'(done), 48'd0);
    end
    applyStimulus(64'h133457799BBCDFF1, 1'b0, 100, -1);
    @(negedge clk);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 100, 3);
    saved_next = exp_keys[4];
    new_key = {$urandom, $urandom};
    key = new_key;
    decrypt = 1'b1;
    start = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    subkey_ready = 1'b0;
    checkOutput("restart_valid", 48'(subkey_valid), 48'd1);
    checkOutput("restart_done",  48'(done),         48'd0);
`ifdef DES_KS_RESTART_EN
    build_ref(new_key);
    checkOutput("restart_idx",    48'(round_idx), 48'd15);
    checkOutput("restart_subkey", subkey,         exp_keys[15]);
`else
    checkOutput("restart_idx",    48'(round_idx), 48'd4);
    checkOutput("restart_subkey", subkey,         saved_next);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkResetState("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
